aes50_rmii_rx_deframer: RTL and testbench
=========================================

AES50_RMII_RX_DEFRAMER -- requirements
Module: aes50_rmii_rx_deframer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, the minimum frame length in bytes including FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1522, the maximum frame length in bytes including FCS.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  in  1  sclk recovered by the RMII rxd capture path (50 MHz); sole clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port rxd_in  in  3  captured RMII sample: [2]=crs_dv, [1:0]=dibit.
REQ-007 SHALL have port m_data  out  8  received byte.
REQ-008 SHALL have port m_valid  out  1  m_data valid for exactly one cycle.
REQ-009 SHALL have port m_last  out  1  final byte of frame; qualified by m_valid.
REQ-010 SHALL have port m_err  out  1  frame bad (CRC, runt, oversize, alignment); qualified by m_last.
REQ-011 SHALL have port frames_ok  out  16  count of good frames, saturating.
REQ-012 SHALL have port frames_err  out  16  count of bad frames, saturating.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA, DROP; no backpressure.
REQ-014 IDLE: crs_dv=1 with dibit 01 SHALL go to PREAMBLE; any other sample SHALL stay in IDLE.
REQ-015 PREAMBLE: dibit 01 SHALL stay; dibit 11 (SFD end) SHALL go to DATA with dibit counter 0; dibit 00/10 or crs_dv=0 SHALL return to IDLE with no output and no counter change.
REQ-016 DATA SHALL assemble bytes LSB-dibit first: first dibit goes to bits[1:0], fourth to bits[7:6].
REQ-017 Each completed byte SHALL enter a one-byte hold register; the previous held byte SHALL be emitted (m_valid=1, m_last=0) in the cycle after completion, giving a latency of 4 dibits + 1 cycle.
REQ-018 crs_dv=0 in DATA with dibit counter 0 SHALL emit the held byte with m_last=1 in the next cycle and return to IDLE.
REQ-019 crs_dv=0 with dibit counter nonzero SHALL emit the held byte with m_last=1 and m_err=1 (alignment) and discard the partial byte.
REQ-020 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) SHALL run over every assembled byte including FCS; a good frame leaves residue 0xDEBB20E3 (0xC704DD7B reflected per the chosen implementation, fixed in package).
REQ-021 On m_last, m_err SHALL be 1 if the residue mismatches, byte count < MIN_LEN, or alignment error.
REQ-022 The byte counter SHALL be 11 bits; on completing byte MAX_LEN+1 while crs_dv=1, the block SHALL emit the held byte with m_last=1 and m_err=1, then enter DROP.
REQ-023 DROP SHALL produce no output until crs_dv=0, then return to IDLE.
REQ-024 A frame with zero data bytes SHALL produce no output and no counter change.
REQ-025 Each m_last SHALL increment exactly one of frames_ok (m_err=0) or frames_err (m_err=1); both SHALL hold at 0xFFFF.
REQ-026 m_valid=0 SHALL force m_last=0 and m_err=0.

Reset
REQ-027 Reset SHALL clear all outputs, counters, and hold/CRC state; the state SHALL go to IDLE.
REQ-028 Reset mid-frame SHALL discard the frame without m_last; the block SHALL resynchronise on the next preamble.

Structure
REQ-029 State enum, CRC polynomial, CRC init, residue constant, and SFD dibit SHALL live in package aes50_pkg.
REQ-030 The byte-wide CRC update SHALL be a separate sub-module, aes50_crc32_byte (combinational, 32+8 in -> 32 out).

Verification
REQ-031 A 7-byte preamble plus SFD, 64-byte frame with valid FCS SHALL produce 64 m_valid, m_last on byte 64, m_err=0, and frames_ok=1.
REQ-032 The same frame with data byte 10 bit 3 flipped SHALL give m_last with m_err=1, frames_err=1, and frames_ok unchanged.
REQ-033 A 65-byte frame plus one extra dibit before crs_dv drops SHALL produce 65 bytes with m_last/m_err=1 on byte 65.
REQ-034 A 1600-byte frame SHALL produce m_last/m_err=1 on byte 1522, then no output for the remaining bytes; the next good frame SHALL be received cleanly.
REQ-035 A 20-byte frame with a correct CRC SHALL produce m_err=1 (runt).
REQ-036 Preamble then dibit 10 SHALL produce no output; reset_n=0 at byte 30 SHALL suppress m_last, and the following frame SHALL be good.

Source files
------------

// File: rtl/aes50_pkg.sv
// Shared state encoding and CRC-32 constants for the AES50 RMII receive deframer.
package aes50_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  // Register value left by a good frame (data + FCS) in the LSB-first update, no final inversion.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = bit_rev32(CRC_POLY);

endpackage

// File: rtl/aes50_rmii_rx_deframer_if.sv
// Received-byte stream bundle: one byte per m_valid pulse, m_last/m_err mark the frame end.
interface aes50_rmii_rx_deframer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;

  modport master (output m_data, m_valid, m_last, m_err);
  modport slave  (input  m_data, m_valid, m_last, m_err);
endinterface

// File: rtl/aes50_crc32_byte.sv
// One-byte step of the reflected CRC-32 (LSB of the byte enters first).
module aes50_crc32_byte
  import aes50_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  // NOTE: combinational logic uses blocking '=' so each bit step sees the previous one;
  // clocked state elsewhere uses non-blocking '<=' so all registers update together.
  always_comb begin
    o_crc = i_crc ^ {24'd0, i_data};
    for (int i = 0; i < 8; i++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC_POLY_REFL) : (o_crc >> 1);
    end
  end

endmodule

// File: rtl/aes50_rmii_rx_deframer.sv
// RMII dibit receiver: strips preamble/SFD, assembles bytes, checks FCS/length/alignment
// and streams bytes out one behind the assembler so the final byte can carry m_last.
module aes50_rmii_rx_deframer
  import aes50_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  rxd_in,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_err,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_err
);

  localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
  localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

  logic        w_crs_dv;
  logic [1:0]  w_dibit;
  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_dibit_cnt;
  logic [5:0]  r_shift;
  logic [7:0]  r_hold;
  logic        r_hold_vld;
  logic [10:0] r_byte_cnt;
  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;
  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic        w_oversize;
  logic        w_emit;
  logic        w_last;
  logic        w_err;
  logic [15:0] r_frames_ok;
  logic [15:0] r_frames_err;

  aes50_rmii_rx_deframer_if u_stream ();

  assign w_crs_dv    = rxd_in[2];
  assign w_dibit     = rxd_in[1:0];
  assign w_byte      = {w_dibit, r_shift};
  assign w_byte_done = (r_state == ST_DATA) && w_crs_dv && (r_dibit_cnt == 2'd3);
  assign w_oversize  = w_byte_done && (r_byte_cnt == MAX_CNT);

  aes50_crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_crs_dv && (w_dibit == PREAMBLE_DIBIT)) w_state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!w_crs_dv)                     w_state_nxt = ST_IDLE;
        else if (w_dibit == SFD_DIBIT)     w_state_nxt = ST_DATA;
        else if (w_dibit != PREAMBLE_DIBIT) w_state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        if (!w_crs_dv)       w_state_nxt = ST_IDLE;
        else if (w_oversize) w_state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (!w_crs_dv) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The held byte is released either when the next byte completes or when carrier drops.
  always_comb begin
    w_emit = 1'b0;
    w_last = 1'b0;
    w_err  = 1'b0;
    if (r_state == ST_DATA) begin
      if (!w_crs_dv) begin
        if (r_hold_vld) begin
          w_emit = 1'b1;
          w_last = 1'b1;
          w_err  = (r_dibit_cnt != 2'd0) || (r_crc != CRC_RESIDUE) || (r_byte_cnt < MIN_CNT);
        end
      end else if (w_byte_done && r_hold_vld) begin
        w_emit = 1'b1;
        w_last = w_oversize;
        w_err  = w_oversize;
      end
    end
  end

  // NOTE: hold, shift and CRC state are all reset, so a reset mid-frame leaves nothing stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dibit_cnt <= 2'd0;
      r_shift     <= 6'd0;
      r_hold      <= 8'd0;
      r_hold_vld  <= 1'b0;
      r_byte_cnt  <= 11'd0;
      r_crc       <= CRC_INIT;
    end else if (r_state != ST_DATA) begin
      r_dibit_cnt <= 2'd0;
      r_hold_vld  <= 1'b0;
      r_byte_cnt  <= 11'd0;
      r_crc       <= CRC_INIT;
    end else if (w_crs_dv) begin
      r_dibit_cnt <= r_dibit_cnt + 2'd1;
      r_shift     <= {w_dibit, r_shift[5:2]};
      if (w_byte_done) begin
        r_hold     <= w_byte;
        r_hold_vld <= 1'b1;
        r_byte_cnt <= r_byte_cnt + 11'd1;
        r_crc      <= w_crc_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_stream.m_data  <= 8'd0;
      u_stream.m_valid <= 1'b0;
      u_stream.m_last  <= 1'b0;
      u_stream.m_err   <= 1'b0;
      r_frames_ok      <= 16'd0;
      r_frames_err     <= 16'd0;
    end else begin
      u_stream.m_valid <= w_emit;
      u_stream.m_last  <= w_last;
      u_stream.m_err   <= w_err;
      if (w_emit) u_stream.m_data <= r_hold;
      if (w_last) begin
        if (w_err) begin
          if (r_frames_err != 16'hFFFF) r_frames_err <= r_frames_err + 16'd1;
        end else begin
          if (r_frames_ok != 16'hFFFF) r_frames_ok <= r_frames_ok + 16'd1;
        end
      end
    end
  end

  assign m_data     = u_stream.m_data;
  assign m_valid    = u_stream.m_valid;
  assign m_last     = u_stream.m_last;
  assign m_err      = u_stream.m_err;
  assign frames_ok  = r_frames_ok;
  assign frames_err = r_frames_err;

endmodule

// File: tb/tb_aes50_rmii_rx_deframer.sv
// Bench for the RMII deframer: table of frame shapes, hand-built corner sequences and
// random frames, all judged by a frame-level reference model.
module tb_aes50_rmii_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;
  localparam int IPG     = 12;
  localparam int NV      = 12;

  typedef logic [7:0] byte_q_t [$];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct {
    int len;
    int extra;
    bit good_fcs;
    bit flip;
    int exp_n;
    bit exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  rxd_in;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;

  aes50_rmii_rx_deframer_if u_if ();

  aes50_rmii_rx_deframer #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd_in     (rxd_in),
    .m_data     (u_if.m_data),
    .m_valid    (u_if.m_valid),
    .m_last     (u_if.m_last),
    .m_err      (u_if.m_err),
    .frames_ok  (frames_ok),
    .frames_err (frames_err)
  );

  always #5 clk = ~clk;

  int    n_tests   = 0;
  int    n_fail    = 0;
  int    qual_viol = 0;
  int    model_ok  = 0;
  int    model_err = 0;
  beat_t cap[$];
  vec_t  vecs[NV];

  // Outputs are sampled on the falling edge, half a cycle away from the launching edge.
  always @(negedge clk) begin
    if (u_if.m_valid) cap.push_back({u_if.m_data, u_if.m_last, u_if.m_err});
    else if (u_if.m_last || u_if.m_err) qual_viol++;
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input byte_q_t q, input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // A frame is good when its last four bytes are the little-endian FCS of the rest.
  function automatic bit fcs_ok(input byte_q_t q);
    int n = q.size();
    if (n < 4) return 1'b0;
    return {q[n-1], q[n-2], q[n-3], q[n-4]} == crc32(q, n - 4);
  endfunction

  task automatic model_expect(input byte_q_t q, input int extra, output int n, output bit err);
    if (q.size() > MAX_LEN) begin
      n   = MAX_LEN;
      err = 1'b1;
    end else begin
      n   = q.size();
      err = (n > 0) && ((extra != 0) || (n < MIN_LEN) || !fcs_ok(q));
    end
  endtask

  task automatic build_frame(input int len, input bit good, input bit flip, output byte_q_t q);
    logic [31:0] fcs;
    q.delete();
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    if (len >= 4) begin
      fcs        = crc32(q, len - 4);
      q[len-4]   = fcs[7:0];
      q[len-3]   = fcs[15:8];
      q[len-2]   = fcs[23:16];
      q[len-1]   = fcs[31:24];
      if (!good) q[len-1] = q[len-1] ^ 8'h01;
    end
    if (flip && len > 10) q[9] = q[9] ^ 8'h08;
  endtask

  task automatic drive(input logic [2:0] v);
    rxd_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_preamble();
    repeat (31) drive({1'b1, 2'b01});
    drive({1'b1, 2'b11});
  endtask

  task automatic send_bytes(input byte_q_t q, input int count);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = q[i];
      for (int k = 0; k < 4; k++) drive({1'b1, b[2*k +: 2]});
    end
  endtask

  task automatic send_frame(input byte_q_t q, input int extra);
    send_preamble();
    send_bytes(q, q.size());
    for (int e = 0; e < extra; e++) drive({1'b1, 2'($urandom)});
    repeat (IPG) drive(3'b000);
  endtask

  task automatic check_frame(input string name, input byte_q_t q, input int exp_n, input bit exp_err);
    int   last_pos = -1;
    int   n_last   = 0;
    int   mism     = 0;
    logic err_at   = 1'b0;
    for (int j = 0; j < cap.size(); j++) begin
      if (j < q.size() && cap[j].data !== q[j]) mism++;
      if (cap[j].last) begin
        n_last++;
        if (last_pos < 0) begin
          last_pos = j;
          err_at   = cap[j].err;
        end
      end
    end
    check({name, " count"}, cap.size(), exp_n);
    check({name, " data_mismatches"}, mism, 0);
    check({name, " last_pos"}, last_pos, exp_n - 1);
    check({name, " n_last"}, n_last, (exp_n > 0) ? 1 : 0);
    if (exp_n > 0) begin
      check({name, " m_err"}, err_at, exp_err);
      if (exp_err) model_err++;
      else         model_ok++;
    end
    check({name, " frames_ok"}, frames_ok, model_ok);
    check({name, " frames_err"}, frames_err, model_err);
    cap.delete();
  endtask

  initial begin
    byte_q_t q;
    int      n;
    bit      err;
    int      len;
    int      extra;
    string   nm;

    //            len  extra good flip exp_n exp_err
    vecs[0]  = '{  64,  0, 1'b1, 1'b0,   64, 1'b0};  // nominal good frame
    vecs[1]  = '{  64,  0, 1'b1, 1'b1,   64, 1'b1};  // byte 10 bit 3 flipped
    vecs[2]  = '{  65,  1, 1'b1, 1'b0,   65, 1'b1};  // one trailing dibit
    vecs[3]  = '{  20,  0, 1'b1, 1'b0,   20, 1'b1};  // runt with good FCS
    vecs[4]  = '{1600,  0, 1'b1, 1'b0, 1522, 1'b1};  // oversize, truncated
    vecs[5]  = '{ 100,  0, 1'b1, 1'b0,  100, 1'b0};  // clean after oversize
    vecs[6]  = '{1522,  0, 1'b1, 1'b0, 1522, 1'b0};  // exactly maximum
    vecs[7]  = '{1523,  0, 1'b1, 1'b0, 1522, 1'b1};  // one byte over maximum
    vecs[8]  = '{  63,  0, 1'b1, 1'b0,   63, 1'b1};  // one byte under minimum
    vecs[9]  = '{   0,  0, 1'b1, 1'b0,    0, 1'b0};  // SFD then carrier drop
    vecs[10] = '{ 128,  0, 1'b0, 1'b0,  128, 1'b1};  // corrupted FCS
    vecs[11] = '{  64,  3, 1'b1, 1'b0,   64, 1'b1};  // three trailing dibits

    reset_n = 1'b0;
    rxd_in  = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset m_valid", u_if.m_valid, 0);
    check("reset m_last", u_if.m_last, 0);
    check("reset m_err", u_if.m_err, 0);
    check("reset m_data", u_if.m_data, 0);
    check("reset frames_ok", frames_ok, 0);
    check("reset frames_err", frames_err, 0);
    reset_n = 1'b1;
    repeat (4) drive(3'b000);

    for (int i = 0; i < NV; i++) begin
      build_frame(vecs[i].len, vecs[i].good_fcs, vecs[i].flip, q);
      send_frame(q, vecs[i].extra);
      nm = $sformatf("vec%0d_len%0d", i, vecs[i].len);
      check_frame(nm, q, vecs[i].exp_n, vecs[i].exp_err);
    end

    // Preamble broken by dibit 10: nothing comes out.
    repeat (10) drive({1'b1, 2'b01});
    drive({1'b1, 2'b10});
    repeat (IPG) drive(3'b000);
    check("abort_dibit10 count", cap.size(), 0);
    check("abort_dibit10 frames_ok", frames_ok, model_ok);
    check("abort_dibit10 frames_err", frames_err, model_err);
    cap.delete();

    // Carrier lost inside the preamble.
    repeat (6) drive({1'b1, 2'b01});
    repeat (IPG) drive(3'b000);
    check("abort_crs count", cap.size(), 0);
    check("abort_crs frames_err", frames_err, model_err);
    cap.delete();

    for (int r = 0; r < 30; r++) begin
      len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 180));
      extra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      build_frame(len, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, q);
      model_expect(q, extra, n, err);
      nm = $sformatf("rand%0d_len%0d_x%0d", r, len, extra);
      send_frame(q, extra);
      check_frame(nm, q, n, err);
    end

    // Reset during byte 31: 29 bytes already released, no frame end, counters cleared.
    build_frame(64, 1'b1, 1'b0, q);
    send_preamble();
    send_bytes(q, 30);
    drive({1'b1, q[30][1:0]});
    reset_n = 1'b0;
    repeat (3) drive(3'b000);
    reset_n = 1'b1;
    repeat (IPG) drive(3'b000);
    model_ok  = 0;
    model_err = 0;
    n = 0;
    foreach (cap[j]) if (cap[j].last) n++;
    check("midreset count", cap.size(), 29);
    check("midreset n_last", n, 0);
    check("midreset frames_ok", frames_ok, 0);
    check("midreset frames_err", frames_err, 0);
    cap.delete();

    build_frame(64, 1'b1, 1'b0, q);
    send_frame(q, 0);
    check_frame("after_reset", q, 64, 1'b0);

    check("unqualified last/err cycles", qual_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
